// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter owner and single-word instruction fetcher
//
// Holds the CPU program counter and fetches one DATA_W instruction per request.
// Memory side uses a req/ack handshake; decode side uses a valid/ready handshake.
// A branch redirect from execute flushes any held or in-flight instruction.
//
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   defined   : a branch target with bit 0 set raises sticky misalign and halts fetching until rst
//   undefined : bit 0 of the target is silently cleared, misalign is tied low
//
// Ports
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous active-high reset
//   mem_req       out  1       fetch request to instruction memory
//   mem_addr      out  ADDR_W  fetch address, always equal to the pc register
//   mem_ack       in   1       mem_rdata is valid this cycle
//   mem_rdata     in   DATA_W  instruction word from memory
//   instr_valid   out  1       instr / instr_pc valid toward decode
//   instr         out  DATA_W  fetched instruction
//   instr_pc      out  ADDR_W  address instr was fetched from
//   instr_ready   in   1       decode accepts instr this cycle
//   branch_taken  in   1       one-cycle redirect request
//   branch_target in   ADDR_W  redirect address
//   misalign      out  1       sticky misaligned-target flag

module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              misalign
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              req_q, req_n;
  logic              valid_q, valid_n;
  logic [DATA_W-1:0] instr_q, instr_n;
  logic [ADDR_W-1:0] ipc_q, ipc_n;
  logic              pend_q, pend_n;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_n;

  // Instructions are 16-bit aligned, so the low target bit is never a legal fetch address.
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_next_seq;

  assign tgt         = branch_target & ~ADDR_W'(1);
  assign pc_next_seq = pc + ADDR_W'(PC_INC);

`ifdef IFU_MISALIGN_TRAP_EN
  logic mis_q, mis_n;
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

  assign mem_req     = req_q;
  assign mem_addr    = pc;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_q      <= req_n;
      valid_q    <= valid_n;
      instr_q    <= instr_n;
      ipc_q      <= ipc_n;
      pend_q     <= pend_n;
      pend_tgt_q <= pend_tgt_n;
`ifdef IFU_MISALIGN_TRAP_EN
      mis_q      <= mis_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_n      = req_q;
    valid_n    = valid_q;
    instr_n    = instr_q;
    ipc_n      = ipc_q;
    pend_n     = pend_q;
    pend_tgt_n = pend_tgt_q;
`ifdef IFU_MISALIGN_TRAP_EN
    mis_n      = mis_q;
`endif

    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        req_n   = 1'b1;
        if (branch_taken) pc_n = tgt;
      end

      S_REQ: begin
        req_n = 1'b1;
        if (mem_ack) begin
          if (branch_taken) begin
            // Newest redirect wins over an older pending one; the returned word is stale.
            pc_n   = tgt;
            pend_n = 1'b0;
          end else if (pend_q) begin
            pc_n   = pend_tgt_q;
            pend_n = 1'b0;
          end else begin
            instr_n = mem_rdata;
            ipc_n   = pc;
            valid_n = 1'b1;
            pc_n    = pc_next_seq;
            req_n   = 1'b0;
            state_n = S_HOLD;
          end
        end else if (branch_taken) begin
          // Address must stay stable until ack, so park the redirect until the current access completes.
          pend_n     = 1'b1;
          pend_tgt_n = tgt;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          pc_n    = tgt;
          req_n   = 1'b1;
          state_n = S_REQ;
        end else if (instr_ready) begin
          valid_n = 1'b0;
          req_n   = 1'b1;
          state_n = S_REQ;
        end
      end

`ifdef IFU_MISALIGN_TRAP_EN
      S_HALT: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
      end
`endif

      default: begin
        state_n = S_IDLE;
        req_n   = 1'b0;
        valid_n = 1'b0;
      end
    endcase

`ifdef IFU_MISALIGN_TRAP_EN
    // A misaligned redirect overrides whatever the state logic chose and freezes the pc.
    if (branch_taken && branch_target[0] && state != S_HALT) begin
      mis_n   = 1'b1;
      req_n   = 1'b0;
      valid_n = 1'b0;
      pend_n  = 1'b0;
      pc_n    = pc;
      state_n = S_HALT;
    end
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        misalign;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .misalign     (misalign)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mem_auto = 1'b0;
  int   man_req_cnt = 0;
  int   man_ack_cnt = 0;

  function automatic logic [15:0] memword(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = memword(pc);
    sb.push_back(e);
  endtask

  // Memory: auto mode acks one cycle after seeing a request; manual mode acks once per main-issued token.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      mem_ack = 1'b0;
    end else if (mem_auto) begin
      if (mem_req && !mem_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = memword(mem_addr);
      end else begin
        mem_ack = 1'b0;
      end
    end else if (man_req_cnt != man_ack_cnt) begin
      mem_ack   = 1'b1;
      mem_rdata = memword(mem_addr);
      man_ack_cnt++;
    end else begin
      mem_ack = 1'b0;
    end
  end

  // Monitor: every instruction decode actually consumes must be the next expected one.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !branch_taken) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_instr: got pc %h instr %h want none", instr_pc, instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("instr_pc", 32'(instr_pc), 32'(e.pc));
        check("instr", 32'(instr), 32'(e.data));
      end
    end
  end

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      if (sb.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    sb.delete();
  endtask

  task automatic wait_valid(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    total++;
    bad++;
    $display("FAIL valid_timeout: got instr_valid 0 want 1");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    mem_auto     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0000);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_instr_pc", 32'(instr_pc), 32'h0000);
    check("rst_misalign", 32'(misalign), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    do_reset();

    // Sequential fetch 0,2,4,6 with zero-wait decode.
    @(posedge clk);
    #1;
    mem_auto    = 1'b1;
    instr_ready = 1'b1;
    rst         = 1'b0;
    push(16'h0000); push(16'h0002); push(16'h0004); push(16'h0006);
    @(negedge clk);
    check("idle_req_low", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'h0000);
    wait_drain(100);
    #1 instr_ready = 1'b0;

    // Backpressure: held instruction stays stable and no request is issued.
    wait_valid(50);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_pc", 32'(instr_pc), 32'h0008);
      check("hold_instr", 32'(instr), 32'(memword(16'h0008)));
      check("hold_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    push(16'h0008);
    @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_drain(20);
    #1 instr_ready = 1'b0;

    // PC wrap at top of address space.
    do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    mem_auto      = 1'b1;
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    push(16'hFFFE); push(16'h0000);
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("wrap_start_addr", 32'(mem_addr), 32'hFFFE);
    wait_drain(50);
    check("wrap_pc_after", 32'(mem_addr), 32'h0002);
    #1 instr_ready = 1'b0;

    // Redirect while a request is outstanding: data for 0x0040 is dropped.
    do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("wait_req", 32'(mem_req), 32'd1);
    check("wait_addr", 32'(mem_addr), 32'h0040);
    @(posedge clk);
    #1;
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("pend_addr_held", 32'(mem_addr), 32'h0040);
    check("pend_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1 man_req_cnt++;
    @(posedge clk);
    @(negedge clk);
    check("redirect_addr", 32'(mem_addr), 32'h0100);
    check("redirect_req", 32'(mem_req), 32'd1);
    check("redirect_no_valid", 32'(instr_valid), 32'd0);
    push(16'h0100);
    mem_auto = 1'b1;
    wait_drain(50);
    #1 instr_ready = 1'b0;

    // Branch and ready together in S_HOLD: branch wins.
    do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_auto = 1'b1;
    wait_valid(50);
    check("hold0_pc", 32'(instr_pc), 32'h0000);
    @(posedge clk);
    #1;
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0200;
    push(16'h0200);
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_addr", 32'(mem_addr), 32'h0200);
    check("flush_req", 32'(mem_req), 32'd1);
    wait_drain(50);
    #1 instr_ready = 1'b0;

    // Misaligned target 0x0101.
    do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    mem_auto      = 1'b1;
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0101;
`ifdef IFU_MISALIGN_TRAP_EN
    @(posedge clk);
    #1 branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mis_flag", 32'(misalign), 32'd1);
      check("mis_req", 32'(mem_req), 32'd0);
      check("mis_valid", 32'(instr_valid), 32'd0);
      check("mis_pc_held", 32'(mem_addr), 32'h0000);
    end
`else
    push(16'h0100);
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("align_addr", 32'(mem_addr), 32'h0100);
    wait_drain(50);
    check("align_no_flag", 32'(misalign), 32'd0);
`endif

    // Reset while waiting for an ack abandons the access.
    do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("midwait_req", 32'(mem_req), 32'd1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
